pcie_link_ctrl: RTL and testbench
=================================

Name: pcie_link_ctrl

Overview:
- Link sequencer for the 4-lane striped byte link: tx mux → byte striping → per-lane serializers, with the matching rx path back.
- Brings the link up by sending COM training symbols until every rx lane reports stable COM.
- Then passes upstream data, fills idle cycles with IDL, and periodically inserts SKP ordered sets.
- Drives the symbol select and VALID consumed by the tx mux/striping; runs on the byte clock.

Parameters:
LANES, 4, number of striped lanes checked for lock
LOCK_COUNT, 8, consecutive COM bytes required per lane for lock
TRAIN_TIMEOUT, 1024, TRAIN cycles before abandoning training
SKP_INTERVAL, 256, ACTIVE cycles between SKP insertions
SKP_LEN, 2, SKP symbols per insertion

Ports:
CLK  in  1  byte clock; single clock domain
RESET  in  1  reset, asynchronous, active-low
enable  in  1  link enable; low forces DOWN
retrain  in  1  request to retrain the link
src_valid  in  1  upstream byte available
src_ready  out  1  upstream byte accepted when src_valid&src_ready
rx_data  in  8*LANES  deserialized rx bytes, lane i at [8i+7:8i]
sym_sel  out  2  0=DATA, 1=COM(0xBC), 2=SKP(0x1C), 3=IDL(0x7C)
VALID  out  1  tx symbol valid to the mux/striping
link_up  out  1  registered; 1 in ACTIVE/SKIP
state  out  3  current FSM state for debug
timeout_err  out  1  sticky training timeout flag

Behaviour:
- Reset (RESET=0, async):
  - state=DOWN; sym_sel=IDL; VALID=0; src_ready=0; link_up=0; timeout_err=0.
  - All counters cleared.
- Output decode:
  - sym_sel, VALID and src_ready are combinational from the registered state, plus src_valid.
  - link_up is a flop.
- States: DOWN=0, TRAIN=1, LOCKED=2, ACTIVE=3, SKIP=4.
- Priority each cycle: enable=0 → DOWN; else retrain=1 (state≠DOWN) → TRAIN; else normal transitions.
- DOWN:
  - sym_sel=IDL, VALID=0.
  - enable=1 → TRAIN next cycle.
- TRAIN:
  - sym_sel=COM, VALID=1.
  - Per-lane counter: +1 when its rx byte==0xBC, saturating at LOCK_COUNT; cleared to 0 on any other byte.
  - All lanes ==LOCK_COUNT → LOCKED.
  - Timeout counter +1 per TRAIN cycle. At TRAIN_TIMEOUT-1 without lock → DOWN and timeout_err=1.
  - Lock and timeout in the same cycle: lock wins.
  - On entry to TRAIN, the lane counters and the timeout counter are cleared.
- LOCKED:
  - Lasts exactly LANES cycles: sym_sel=IDL, VALID=1, src_ready=0.
  - Then → ACTIVE. timeout_err is cleared on entry.
- ACTIVE:
  - src_ready=1, VALID=1.
  - sym_sel=DATA when src_valid=1, else IDL.
  - skp counter +1 per ACTIVE cycle. The cycle with skp counter==SKP_INTERVAL-1 still transfers; next state is SKIP.
- SKIP:
  - SKP_LEN cycles of sym_sel=SKP, VALID=1, src_ready=0.
  - Then → ACTIVE with skp counter=0.
- link_up:
  - Rises the cycle after entering ACTIVE.
  - Falls the cycle after leaving ACTIVE/SKIP.
- Retrain behaviour:
  - Retrain during SKIP aborts the set immediately.
  - retrain held high keeps re-entering TRAIN, with counters held cleared.
- Counter widths: $clog2 of the parameter value; no counter wraps past its terminal value.

Optional Feature:
- Macro: PCIE_LINK_CTRL_STATS_EN.
- Defined:
  - Adds output retrain_cnt[7:0]: saturating count of TRAIN entries from LOCKED/ACTIVE/SKIP.
  - Adds output skp_sets[15:0]: wrapping count of completed SKP insertions.
  - Both counters clear on reset.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package pcie_link_pkg holds:
  - state encodings;
  - sym_sel codes;
  - symbol constants COM=8'hBC, SKP=8'h1C, IDL=8'h7C.
- Sub-module lane_lock_det: one per lane, generated LANES times.
  - Inputs: byte, clear.
  - Contains the saturating consecutive-COM counter.
  - Output: locked.

Test Plan:
- Reset with enable=1 and all rx lanes =0xBC:
  - TRAIN the cycle after reset release.
  - LOCKED after 8 matching cycles, then ACTIVE 4 cycles later.
  - link_up=1 the following cycle; sym_sel=COM throughout TRAIN.
- Lane 2 sends 0x00 once at its 6th COM byte:
  - Lock is delayed; lane 2 needs 8 fresh consecutive COM bytes.
  - LOCKED is entered 6 cycles later than in the clean case.
- rx never sends COM:
  - DOWN after 1024 TRAIN cycles, timeout_err=1, then TRAIN again next cycle (enable=1).
  - A later successful lock clears timeout_err in LOCKED.
- ACTIVE with src_valid=1 continuously:
  - 256 bytes accepted, then 2 cycles sym_sel=SKP with src_ready=0, then DATA resumes.
  - src_valid=0 gives sym_sel=IDL.
- retrain pulse during SKIP: next cycle TRAIN, link_up low one cycle later, SKP set aborted.
- RESET asserted mid-ACTIVE: all outputs return to reset values immediately, asynchronously, with no clock edge required.

Source files
------------

// File: rtl/pcie_link_pkg.sv
// Shared encodings for the striped-link sequencer: FSM states, tx symbol selects
// and the 8b ordered-set symbol values.
package pcie_link_pkg;

    typedef enum logic [2:0] {
        StDown   = 3'd0,
        StTrain  = 3'd1,
        StLocked = 3'd2,
        StActive = 3'd3,
        StSkip   = 3'd4
    } link_state_e;

    typedef enum logic [1:0] {
        SymData = 2'd0,
        SymCom  = 2'd1,
        SymSkp  = 2'd2,
        SymIdl  = 2'd3
    } sym_sel_e;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;

endpackage

// File: rtl/lane_lock_det.sv
// Per-lane COM lock detector: saturating count of consecutive COM bytes.
module lane_lock_det
    import pcie_link_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] rx_byte,
    input  logic       clear,
    output logic       locked
);

    localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_COUNT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (rx_byte != COM)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Lock includes this cycle's byte, so LOCK_COUNT matching bytes are enough.
    assign locked = (cnt_d == CNT_MAX);

endmodule

// File: rtl/pcie_link_ctrl.sv
// Link sequencer for the striped byte link: COM training, data/IDL fill, SKP insertion.
// Optional stats outputs (retrain_cnt, skp_sets) under `PCIE_LINK_CTRL_STATS_EN.
module pcie_link_ctrl
    import pcie_link_pkg::*;
#(
    parameter int unsigned LANES         = 4,
    parameter int unsigned LOCK_COUNT    = 8,
    parameter int unsigned TRAIN_TIMEOUT = 1024,
    parameter int unsigned SKP_INTERVAL  = 256,
    parameter int unsigned SKP_LEN       = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               enable,
    input  logic               retrain,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [8*LANES-1:0] rx_data,
    output logic [1:0]         sym_sel,
    output logic               VALID,
    output logic               link_up,
    output logic [2:0]         state,
    output logic               timeout_err
`ifdef PCIE_LINK_CTRL_STATS_EN
    ,
    output logic [7:0]         retrain_cnt,
    output logic [15:0]        skp_sets
`endif
);

    localparam int unsigned TMO_W  = $clog2(TRAIN_TIMEOUT);
    localparam int unsigned SKP_W  = $clog2(SKP_INTERVAL);
    localparam int unsigned PH_MAX = (LANES > SKP_LEN) ? LANES : SKP_LEN;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TRAIN_TIMEOUT - 1);
    localparam logic [SKP_W-1:0] SKP_LAST    = SKP_W'(SKP_INTERVAL - 1);
    localparam logic [PH_W-1:0]  LOCKED_LAST = PH_W'(LANES - 1);
    localparam logic [PH_W-1:0]  SKIP_LAST   = PH_W'(SKP_LEN - 1);

    link_state_e      state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [SKP_W-1:0] skp_q, skp_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             link_up_q, link_up_d;
    logic             terr_q, terr_d;
    logic [LANES-1:0] lane_locked;
    logic             train_run;

    // Lane and timeout counters only advance in an undisturbed TRAIN cycle.
    assign train_run = (state_q == StTrain) && enable && !retrain;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_lock_det #(
            .LOCK_COUNT(LOCK_COUNT)
        ) u_lane_lock_det (
            .CLK    (CLK),
            .RESET  (RESET),
            .rx_byte(rx_data[8*i +: 8]),
            .clear  (!train_run),
            .locked (lane_locked[i])
        );
    end

    always_comb begin
        state_d = state_q;
        terr_d  = terr_q;
        if (!enable) begin
            state_d = StDown;
        end else if (retrain && (state_q != StDown)) begin
            state_d = StTrain;
        end else begin
            unique case (state_q)
                StDown:   state_d = StTrain;
                StTrain: begin
                    if (&lane_locked) begin
                        state_d = StLocked;
                        terr_d  = 1'b0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = StDown;
                        terr_d  = 1'b1;
                    end
                end
                StLocked: if (ph_q == LOCKED_LAST) state_d = StActive;
                StActive: if (skp_q == SKP_LAST) state_d = StSkip;
                StSkip:   if (ph_q == SKIP_LAST) state_d = StActive;
                default:  state_d = StDown;
            endcase
        end
    end

    always_comb begin
        tmo_d = '0;
        if (train_run) begin
            tmo_d = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1;
        end
        skp_d = ((state_q == StActive) && (state_d == StActive)) ? skp_q + 1'b1 : '0;
        ph_d  = '0;
        if ((state_d == state_q) && ((state_q == StLocked) || (state_q == StSkip))) begin
            ph_d = ph_q + 1'b1;
        end
        link_up_d = (state_q == StActive) || (state_q == StSkip);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= StDown;
            tmo_q     <= '0;
            skp_q     <= '0;
            ph_q      <= '0;
            link_up_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            skp_q     <= skp_d;
            ph_q      <= ph_d;
            link_up_q <= link_up_d;
            terr_q    <= terr_d;
        end
    end

    always_comb begin
        sym_sel   = SymIdl;
        VALID     = 1'b0;
        src_ready = 1'b0;
        unique case (state_q)
            StDown:   ;
            StTrain: begin
                sym_sel = SymCom;
                VALID   = 1'b1;
            end
            StLocked: VALID = 1'b1;
            StActive: begin
                sym_sel   = src_valid ? SymData : SymIdl;
                VALID     = 1'b1;
                src_ready = 1'b1;
            end
            StSkip: begin
                sym_sel = SymSkp;
                VALID   = 1'b1;
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign link_up     = link_up_q;
    assign timeout_err = terr_q;

`ifdef PCIE_LINK_CTRL_STATS_EN
    logic [7:0]  retrain_cnt_q;
    logic [15:0] skp_sets_q;
    logic        retrain_hit;

    assign retrain_hit = (state_d == StTrain) &&
                         ((state_q == StLocked) || (state_q == StActive) || (state_q == StSkip));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            retrain_cnt_q <= '0;
            skp_sets_q    <= '0;
        end else begin
            if (retrain_hit && (retrain_cnt_q != 8'hFF)) begin
                retrain_cnt_q <= retrain_cnt_q + 1'b1;
            end
            if ((state_q == StSkip) && (state_d == StActive)) begin
                skp_sets_q <= skp_sets_q + 1'b1;
            end
        end
    end

    assign retrain_cnt = retrain_cnt_q;
    assign skp_sets    = skp_sets_q;
`endif

endmodule

// File: tb/tb_pcie_link_ctrl.sv
// Directed bench for pcie_link_ctrl: per-cycle expectations queued and checked at negedge.
module tb_pcie_link_ctrl;

    localparam int LANES = 4;

    localparam logic [2:0] S_DOWN   = 3'd0;
    localparam logic [2:0] S_TRAIN  = 3'd1;
    localparam logic [2:0] S_LOCKED = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_SKIP   = 3'd4;

    localparam logic [1:0] Y_DATA = 2'd0;
    localparam logic [1:0] Y_COM  = 2'd1;
    localparam logic [1:0] Y_SKP  = 2'd2;
    localparam logic [1:0] Y_IDL  = 2'd3;

    logic               CLK = 1'b0;
    logic               RESET = 1'b0;
    logic               enable = 1'b0;
    logic               retrain = 1'b0;
    logic               src_valid = 1'b0;
    logic               src_ready;
    logic [8*LANES-1:0] rx_data;
    logic [1:0]         sym_sel;
    logic               VALID;
    logic               link_up;
    logic [2:0]         state;
    logic               timeout_err;
`ifdef PCIE_LINK_CTRL_STATS_EN
    logic [7:0]         retrain_cnt;
    logic [15:0]        skp_sets;
`endif

    pcie_link_ctrl u_dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .enable     (enable),
        .retrain    (retrain),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .rx_data    (rx_data),
        .sym_sel    (sym_sel),
        .VALID      (VALID),
        .link_up    (link_up),
        .state      (state),
        .timeout_err(timeout_err)
`ifdef PCIE_LINK_CTRL_STATS_EN
        ,
        .retrain_cnt(retrain_cnt),
        .skp_sets   (skp_sets)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        logic [8:0] v;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   accepted   = 0;

    task automatic expect_out(input string tag, input logic [2:0] st, input logic [1:0] sym,
                              input logic vld, input logic rdy, input logic lnk,
                              input logic terr);
        exp_t e;
        e.tag = tag;
        e.v   = {st, sym, vld, rdy, lnk, terr};
        sb.push_back(e);
    endtask

    task automatic compare_now();
        exp_t       e;
        logic [8:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {state, sym_sel, VALID, src_ready, link_up, timeout_err};
            compared++;
            assert (obs === e.v) else begin
                mismatched++;
                $error("FAIL %s: observed st=%0d sym=%0d vld=%b rdy=%b link=%b terr=%b, expected st=%0d sym=%0d vld=%b rdy=%b link=%b terr=%b",
                       e.tag, obs[8:6], obs[5:4], obs[3], obs[2], obs[1], obs[0],
                       e.v[8:6], e.v[5:4], e.v[3], e.v[2], e.v[1], e.v[0]);
            end
        end
    endtask

    // One byte-clock cycle: queue the expectation, check at negedge, move past next posedge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [1:0] sym,
                       input logic vld, input logic rdy, input logic lnk, input logic terr);
        expect_out(tag, st, sym, vld, rdy, lnk, terr);
        @(negedge CLK);
        if (src_valid && src_ready) accepted++;
        compare_now();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rx(input logic [7:0] b);
        rx_data = {LANES{b}};
    endtask

    initial begin
        set_rx(8'hBC);
        enable = 1'b1;
        #2;
        cyc("reset_a", S_DOWN, Y_IDL, 0, 0, 0, 0);
        cyc("reset_b", S_DOWN, Y_IDL, 0, 0, 0, 0);
        RESET = 1'b1;
        cyc("reset_release", S_DOWN, Y_IDL, 0, 0, 0, 0);

        for (int i = 1; i <= 8; i++) cyc($sformatf("train_clean%0d", i), S_TRAIN, Y_COM, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc($sformatf("locked%0d", i), S_LOCKED, Y_IDL, 1, 0, 0, 0);

        // Continuous traffic: 256 accepted bytes, then a 2-symbol SKP set.
        src_valid = 1'b1;
        accepted  = 0;
        for (int i = 0; i < 256; i++) begin
            cyc($sformatf("active%0d", i), S_ACTIVE, Y_DATA, 1, 1, (i == 0) ? 1'b0 : 1'b1, 0);
        end
        cyc("skp1", S_SKIP, Y_SKP, 1, 0, 1, 0);
        cyc("skp2", S_SKIP, Y_SKP, 1, 0, 1, 0);
        compared++;
        assert (accepted === 256) else begin
            mismatched++;
            $error("FAIL accepted_bytes: observed %0d, expected 256", accepted);
        end
        cyc("data_resume", S_ACTIVE, Y_DATA, 1, 1, 1, 0);
        src_valid = 1'b0;
        cyc("idle_fill", S_ACTIVE, Y_IDL, 1, 1, 1, 0);
        for (int i = 2; i < 256; i++) cyc($sformatf("idle%0d", i), S_ACTIVE, Y_IDL, 1, 1, 1, 0);

        // Retrain in the first SKP cycle aborts the set.
        retrain = 1'b1;
        cyc("skp_retrain", S_SKIP, Y_SKP, 1, 0, 1, 0);
        retrain = 1'b0;

        // Lane 2 drops one COM on its 6th byte: lock lands 6 cycles later.
        for (int i = 1; i <= 14; i++) begin
            set_rx(8'hBC);
            if (i == 6) rx_data[23:16] = 8'h00;
            cyc($sformatf("train_glitch%0d", i), S_TRAIN, Y_COM, 1, 0, (i == 1) ? 1'b1 : 1'b0, 0);
        end
        set_rx(8'hBC);
        for (int i = 1; i <= 4; i++) cyc($sformatf("locked_g%0d", i), S_LOCKED, Y_IDL, 1, 0, 0, 0);
        cyc("active_g1", S_ACTIVE, Y_IDL, 1, 1, 0, 0);

        // No COM at all: training times out after 1024 cycles.
        set_rx(8'h00);
        retrain = 1'b1;
        cyc("active_g2", S_ACTIVE, Y_IDL, 1, 1, 1, 0);
        retrain = 1'b0;
        for (int i = 1; i <= 1024; i++) begin
            cyc($sformatf("train_tmo%0d", i), S_TRAIN, Y_COM, 1, 0, (i == 1) ? 1'b1 : 1'b0, 0);
        end
        cyc("timeout_down", S_DOWN, Y_IDL, 0, 0, 0, 1);

        set_rx(8'hBC);
        for (int i = 1; i <= 8; i++) cyc($sformatf("train_after%0d", i), S_TRAIN, Y_COM, 1, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cyc($sformatf("locked_clr%0d", i), S_LOCKED, Y_IDL, 1, 0, 0, 0);
        src_valid = 1'b1;
        cyc("active_r1", S_ACTIVE, Y_DATA, 1, 1, 0, 0);
        cyc("active_r2", S_ACTIVE, Y_DATA, 1, 1, 1, 0);

        // Async reset mid-cycle, well away from any clock edge.
        #2;
        RESET = 1'b0;
        #1;
        expect_out("async_reset", S_DOWN, Y_IDL, 0, 0, 0, 0);
        compare_now();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
